frb_pulse_detector: RTL

Threshold detector that sits directly downstream of the dedispersion and integration stage. It consumes one integrated-power word per spectrum frame (`integ_pow` / `integ_valid`) and tracks a moving-average baseline. When the power rises above the baseline plus a runtime offset, it declares an event. For each event it reports a one-cycle trigger carrying the peak power, the frame index of the peak, and the event width, followed by a programmable holdoff.

---
 rtl/frb_pkg.sv | 25 ++
 rtl/moving_avg.sv | 54 +++++
 rtl/frb_pulse_detector.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/frb_pkg.sv
// Shared definitions for the FRB pulse detector: FSM state encoding, default
// geometry and helpers that derive window depth and running-sum width.
package frb_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP  = 2'd0,
      ST_ARMED   = 2'd1,
      ST_EVENT   = 2'd2,
      ST_HOLDOFF = 2'd3
   } frb_state_e;

   localparam int DEF_DIN_WIDTH = 32;
   localparam int DEF_AVG_LOG2  = 6;
   localparam int AVG_DEPTH     = 1 << DEF_AVG_LOG2;
   localparam int SUM_W         = DEF_DIN_WIDTH + DEF_AVG_LOG2;

   function automatic int avg_depth(input int log2);
      return 1 << log2;
   endfunction

   function automatic int sum_w(input int din_w, input int log2);
      return din_w + log2;
   endfunction

endpackage

// File: rtl/moving_avg.sv
// Boxcar baseline over the last 2^AVG_LOG2 pushed words: circular buffer,
// wrapping write pointer, fill flag and a running sum updated per push.
module moving_avg
   import frb_pkg::*;
#(
   parameter int DIN_WIDTH = DEF_DIN_WIDTH,
   parameter int AVG_LOG2  = DEF_AVG_LOG2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [DIN_WIDTH-1:0] din,
   output logic [DIN_WIDTH-1:0] avg,
   output logic                 full
);

   localparam int DEPTH = avg_depth(AVG_LOG2);
   localparam int SUMW  = sum_w(DIN_WIDTH, AVG_LOG2);
   localparam logic [AVG_LOG2-1:0] PTR_LAST = AVG_LOG2'(DEPTH - 1);

   logic [DIN_WIDTH-1:0] r_buf [DEPTH];
   logic [AVG_LOG2-1:0]  r_ptr;
   logic                 r_full;
   logic [SUMW-1:0]      r_sum;
   logic [DIN_WIDTH-1:0] w_oldest;

   // Until the window has filled once, the slot being overwritten holds stale data.
   assign w_oldest = r_full ? r_buf[r_ptr] : '0;

   // NOTE: the buffer is deliberately left out of reset; r_full masks its stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         r_buf[r_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr  <= '0;
         r_full <= 1'b0;
         r_sum  <= '0;
      end else if (push) begin
         r_ptr <= r_ptr + AVG_LOG2'(1);
         if (r_ptr == PTR_LAST) begin
            r_full <= 1'b1;
         end
         r_sum <= r_sum + SUMW'(din) - SUMW'(w_oldest);
      end
   end

   assign avg  = DIN_WIDTH'(r_sum >> AVG_LOG2);
   assign full = r_full;

endmodule

// File: rtl/frb_pulse_detector.sv
// Threshold event detector: compares each integrated-power word against a moving
// baseline plus offset, tracks peak and width per event, then applies holdoff.
module frb_pulse_detector
   import frb_pkg::*;
#(
   parameter int DIN_WIDTH = DEF_DIN_WIDTH,
   parameter int AVG_LOG2  = DEF_AVG_LOG2,
   parameter int CNT_W     = 32,
   parameter int WIDTH_W   = 8,
   parameter int HOLD_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [DIN_WIDTH-1:0] integ_pow,
   input  logic                 integ_valid,
   input  logic [DIN_WIDTH-1:0] thresh_offset,
   input  logic [HOLD_W-1:0]    holdoff_len,
   output logic                 trigger,
   output logic [DIN_WIDTH-1:0] peak_pow,
   output logic [CNT_W-1:0]     peak_idx,
   output logic [WIDTH_W-1:0]   event_width,
   output logic [DIN_WIDTH-1:0] baseline,
   output logic                 armed
);

   localparam int DEPTH = avg_depth(AVG_LOG2);
   localparam logic [AVG_LOG2-1:0] WARM_LAST = AVG_LOG2'(DEPTH - 1);
   localparam logic [WIDTH_W-1:0]  W_MAX     = '1;

   frb_state_e           r_state;
   logic                 r_armed;
   logic                 r_trigger;
   logic [CNT_W-1:0]     r_frame_cnt;
   logic [AVG_LOG2-1:0]  r_warm_cnt;
   logic [WIDTH_W-1:0]   r_wcnt;
   logic [HOLD_W-1:0]    r_hcnt;
   logic [DIN_WIDTH-1:0] r_pk_pow;
   logic [CNT_W-1:0]     r_pk_idx;
   logic [DIN_WIDTH-1:0] r_peak_pow;
   logic [CNT_W-1:0]     r_peak_idx;
   logic [WIDTH_W-1:0]   r_event_width;

   logic                 w_accept;
   logic [DIN_WIDTH:0]   w_thr;
   logic                 w_above;
   logic                 w_push;
   logic                 w_full;
   logic [DIN_WIDTH-1:0] w_baseline;

   assign w_accept = ce && integ_valid;
   assign w_thr    = {1'b0, w_baseline} + {1'b0, thresh_offset};
   assign w_above  = {1'b0, integ_pow} > w_thr;
   // Baseline freezes during an event; only the below-threshold closing word is pushed.
   assign w_push   = w_accept && !((r_state == ST_EVENT) && w_above);

   moving_avg #(
      .DIN_WIDTH (DIN_WIDTH),
      .AVG_LOG2  (AVG_LOG2)
   ) u_moving_avg (
      .clk  (clk),
      .rst  (rst),
      .push (w_push),
      .din  (integ_pow),
      .avg  (w_baseline),
      .full (w_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_WARMUP;
         r_armed       <= 1'b0;
         r_trigger     <= 1'b0;
         r_frame_cnt   <= '0;
         r_warm_cnt    <= '0;
         r_wcnt        <= '0;
         r_hcnt        <= '0;
         r_pk_pow      <= '0;
         r_pk_idx      <= '0;
         r_peak_pow    <= '0;
         r_peak_idx    <= '0;
         r_event_width <= '0;
      end else begin
         // NOTE: non-blocking only; a later assignment in this block overrides this default.
         r_trigger <= 1'b0;
         if (w_accept) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            case (r_state)
               ST_WARMUP: begin
                  if (w_full || (r_warm_cnt == WARM_LAST)) begin
                     r_state <= ST_ARMED;
                     r_armed <= 1'b1;
                  end else begin
                     r_warm_cnt <= r_warm_cnt + AVG_LOG2'(1);
                  end
               end
               ST_ARMED: begin
                  if (w_above) begin
                     r_state  <= ST_EVENT;
                     r_armed  <= 1'b0;
                     r_pk_pow <= integ_pow;
                     r_pk_idx <= r_frame_cnt;
                     r_wcnt   <= WIDTH_W'(1);
                  end
               end
               ST_EVENT: begin
                  if (w_above && (r_wcnt != W_MAX)) begin
                     r_wcnt <= r_wcnt + WIDTH_W'(1);
                     if (integ_pow > r_pk_pow) begin
                        r_pk_pow <= integ_pow;
                        r_pk_idx <= r_frame_cnt;
                     end
                  end else begin
                     r_trigger     <= 1'b1;
                     r_peak_pow    <= r_pk_pow;
                     r_peak_idx    <= r_pk_idx;
                     r_event_width <= r_wcnt;
                     r_hcnt        <= holdoff_len;
                     if (holdoff_len == '0) begin
                        r_state <= ST_ARMED;
                        r_armed <= 1'b1;
                     end else begin
                        r_state <= ST_HOLDOFF;
                     end
                  end
               end
               ST_HOLDOFF: begin
                  r_hcnt <= r_hcnt - HOLD_W'(1);
                  if (r_hcnt == HOLD_W'(1)) begin
                     r_state <= ST_ARMED;
                     r_armed <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_WARMUP;
                  r_armed <= 1'b0;
               end
            endcase
         end
      end
   end

   assign trigger     = r_trigger;
   assign peak_pow    = r_peak_pow;
   assign peak_idx    = r_peak_idx;
   assign event_width = r_event_width;
   assign baseline    = w_baseline;
   assign armed       = r_armed;

endmodule
